// File: rtl/debounced_switch_bank_pkg.sv
// Shared definitions for the debounced switch bank: bus width, register
// offsets relative to BASE_ADDR, and the register-select encoding used by
// the address decoder.
package debounced_switch_bank_pkg;

   localparam int unsigned BUS_W     = 32;
   localparam int unsigned DATA0_OFF = 0;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_DATA,
      SEL_STATUS,
      SEL_IRQ_EN
   } reg_sel_e;

   // Number of 32-bit data words needed to hold all switch bits.
   function automatic int unsigned calc_nw(input int unsigned num_banks,
                                           input int unsigned bank_w);
      return (num_banks * bank_w + BUS_W - 1) / BUS_W;
   endfunction

   // Byte offset of the STATUS register (directly after the data words).
   function automatic int unsigned status_off(input int unsigned nw);
      return 4 * nw;
   endfunction

   // Byte offset of the IRQ_EN register (after STATUS).
   function automatic int unsigned irq_en_off(input int unsigned nw);
      return 4 * (nw + 1);
   endfunction

endpackage

// File: rtl/debounced_switch_bank_if.sv
// CPU bridge bus for the switch peripheral: byte address, write strobe,
// write data and combinational read data.
interface debounced_switch_bank_if;
   import debounced_switch_bank_pkg::*;

   logic [BUS_W-1:0] addr;
   logic             we;
   logic [BUS_W-1:0] wdata;
   logic [BUS_W-1:0] rdata;

   modport master (output addr, output we, output wdata, input rdata);
   modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/switch_debouncer.sv
// One switch bank: 2-flop synchroniser followed by a whole-bank debouncer.
// The bank vector must differ from the debounced value for DEBOUNCE_CYC
// consecutive cycles before it is adopted; any cycle of agreement restarts
// the count. 'changed' pulses on the edge where q is updated.
module switch_debouncer
   import debounced_switch_bank_pkg::*;
#(
   parameter int unsigned BANK_W       = 8,
   parameter int unsigned DEBOUNCE_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BANK_W-1:0] d,
   output logic [BANK_W-1:0] q,
   output logic              changed
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [BANK_W-1:0] s1_q, s1_d;
   logic [BANK_W-1:0] s2_q, s2_d;
   logic [BANK_W-1:0] deb_q, deb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Next-state: synchroniser shift and debounce counter / state update.
   always_comb begin
      s1_d    = d;
      s2_d    = s1_q;
      deb_d   = deb_q;
      cnt_d   = cnt_q;
      changed = 1'b0;
      if (s2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         // Adopt whatever the bank shows now, even if it varied while counting.
         deb_d   = s2_q;
         cnt_d   = '0;
         changed = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers; everything clears on reset so an aborted debounce leaves no trace.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q  <= '0;
         s2_q  <= '0;
         deb_q <= '0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   assign q = deb_q;

endmodule

// File: rtl/debounced_switch_bank.sv
// Bus-mapped switch input peripheral. Each bank of (optionally active-low)
// pins is synchronised and debounced; the logical values are readable as
// packed data words, per-bank change flags latch into a W1C STATUS register
// and a maskable interrupt is raised from STATUS & IRQ_EN.
module debounced_switch_bank
   import debounced_switch_bank_pkg::*;
#(
   parameter int unsigned NUM_BANKS    = 8,
   parameter int unsigned BANK_W       = 8,
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h7f2c
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_BANKS*BANK_W-1:0]   dip_in,
   debounced_switch_bank_if.slave        bus,
   output logic [NUM_BANKS*BANK_W-1:0]   sw_state,
   output logic                          irq
);

   localparam int unsigned TOTAL_W = NUM_BANKS * BANK_W;
   localparam int unsigned NW      = calc_nw(NUM_BANKS, BANK_W);
   localparam logic [31:0] DATA_END  = 32'(DATA0_OFF + 4 * NW);
   localparam logic [31:0] STAT_OFF  = 32'(status_off(NW));
   localparam logic [31:0] IREN_OFF  = 32'(irq_en_off(NW));

   logic [TOTAL_W-1:0]   pins_log;
   logic [NUM_BANKS-1:0] changed;
   logic [NUM_BANKS-1:0] status_q, status_d;
   logic [NUM_BANKS-1:0] irq_en_q, irq_en_d;
   logic [NW*32-1:0]     data_pad;
   logic [31:0]          byte_off;
   logic [29:0]          word_idx;
   reg_sel_e             sel;
   logic                 unused_bits;

   // Only the word address and the low NUM_BANKS data bits are meaningful.
   assign unused_bits = ^{bus.addr[1:0], bus.wdata};

   assign pins_log = ACTIVE_LOW ? ~dip_in : dip_in;

   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      switch_debouncer #(
         .BANK_W       (BANK_W),
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_deb (
         .clk     (clk),
         .reset   (reset),
         .d       (pins_log[i*BANK_W +: BANK_W]),
         .q       (sw_state[i*BANK_W +: BANK_W]),
         .changed (changed[i])
      );
   end

   // Address decode: classify the word address relative to BASE_ADDR.
   always_comb begin
      byte_off = {bus.addr[31:2], 2'b00} - {BASE_ADDR[31:2], 2'b00};
      word_idx = byte_off[31:2];
      sel      = SEL_NONE;
      if (bus.addr[31:2] >= BASE_ADDR[31:2]) begin
         if (byte_off < DATA_END) begin
            sel = SEL_DATA;
         end else if (byte_off == STAT_OFF) begin
            sel = SEL_STATUS;
         end else if (byte_off == IREN_OFF) begin
            sel = SEL_IRQ_EN;
         end
      end
   end

   // Read mux from registered state; data words are zero-padded above the last bank.
   always_comb begin
      data_pad              = '0;
      data_pad[TOTAL_W-1:0] = sw_state;
      bus.rdata             = '0;
      case (sel)
         SEL_DATA: begin
            for (int j = 0; j < int'(NW); j++) begin
               if (word_idx == 30'(j)) begin
                  bus.rdata = data_pad[j*32 +: 32];
               end
            end
         end
         SEL_STATUS: bus.rdata = 32'(status_q);
         SEL_IRQ_EN: bus.rdata = 32'(irq_en_q);
         default:    bus.rdata = '0;
      endcase
   end

   // Register writes: STATUS is write-1-to-clear with a new change flag taking priority.
   always_comb begin
      status_d = status_q;
      irq_en_d = irq_en_q;
      if (bus.we && (sel == SEL_STATUS)) begin
         status_d = status_q & ~bus.wdata[NUM_BANKS-1:0];
      end
      if (bus.we && (sel == SEL_IRQ_EN)) begin
         irq_en_d = bus.wdata[NUM_BANKS-1:0];
      end
      status_d = status_d | changed;
   end

   // STATUS and IRQ_EN registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         status_q <= '0;
         irq_en_q <= '0;
      end else begin
         status_q <= status_d;
         irq_en_q <= irq_en_d;
      end
   end

   assign irq = |(status_q & irq_en_q);

endmodule

// File: tb/tb_debounced_switch_bank.sv
// Directed bench for debounced_switch_bank: default 8x8 configuration plus a
// 3x4 configuration that fits in a single data word.
module tb_debounced_switch_bank;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] dip1 = '1;
   logic [11:0] dip2 = '1;
   logic [63:0] sw1;
   logic [11:0] sw2;
   logic        irq1, irq2;
   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] rv;

   debounced_switch_bank_if bus1 ();
   debounced_switch_bank_if bus2 ();

   debounced_switch_bank dut1 (
      .clk      (clk),
      .reset    (reset),
      .dip_in   (dip1),
      .bus      (bus1.slave),
      .sw_state (sw1),
      .irq      (irq1)
   );

   debounced_switch_bank #(
      .NUM_BANKS (3),
      .BANK_W    (4)
   ) dut2 (
      .clk      (clk),
      .reset    (reset),
      .dip_in   (dip2),
      .bus      (bus2.slave),
      .sw_state (sw2),
      .irq      (irq2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rd1(input logic [31:0] a, output logic [31:0] d);
      bus1.addr = a;
      bus1.we   = 1'b0;
      #1;
      d = bus1.rdata;
   endtask

   task automatic wr1(input logic [31:0] a, input logic [31:0] d);
      bus1.addr  = a;
      bus1.wdata = d;
      bus1.we    = 1'b1;
      tick();
      bus1.we    = 1'b0;
   endtask

   task automatic rd2(input logic [31:0] a, output logic [31:0] d);
      bus2.addr = a;
      bus2.we   = 1'b0;
      #1;
      d = bus2.rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      dip1  = '1;
      dip2  = '1;
      ticks(3);
      reset = 1'b0;
      tick();
      rd1(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_word0: got %h want %h", d, 32'h0); end
      rd1(32'h7f30, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_word1: got %h want %h", d, 32'h0); end
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
      tests_run++;
      if (irq1 !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", irq1); end
      tests_run++;
      if (sw1 !== 64'h0) begin tests_failed++; $display("FAIL reset_sw_state: got %h want 0", sw1); end
      rd2(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_small_word0: got %h want 0", d); end
   endtask

   task automatic test_latency();
      logic [31:0] d;
      dip1[7:0] = 8'hFE;
      ticks(17);
      rd1(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL latency_early: got %h want %h", d, 32'h0); end
      tick();
      rd1(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h1) begin tests_failed++; $display("FAIL latency_on_time: got %h want %h", d, 32'h1); end
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h1) begin tests_failed++; $display("FAIL latency_status: got %h want %h", d, 32'h1); end
      tests_run++;
      if (irq1 !== 1'b0) begin tests_failed++; $display("FAIL latency_irq_masked: got %b want 0", irq1); end
      rd1(32'h7f3c, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL unmapped_above: got %h want 0", d); end
      rd1(32'h7f28, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL unmapped_below: got %h want 0", d); end
      wr1(32'h7f2c, 32'hFFFF_FFFF);
      rd1(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h1) begin tests_failed++; $display("FAIL data_write_ignored: got %h want %h", d, 32'h1); end
   endtask

   task automatic test_glitch();
      logic [31:0] d;
      wr1(32'h7f34, 32'hFF);
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL w1c_clear_all: got %h want 0", d); end
      dip1[31:24] = 8'h00;
      ticks(10);
      dip1[31:24] = 8'hFF;
      ticks(40);
      tests_run++;
      if (sw1 !== 64'h1) begin tests_failed++; $display("FAIL glitch_sw_state: got %h want %h", sw1, 64'h1); end
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL glitch_status: got %h want 0", d); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      wr1(32'h7f38, 32'h10);
      rd1(32'h7f38, d);
      tests_run++;
      if (d !== 32'h10) begin tests_failed++; $display("FAIL irq_en_readback: got %h want %h", d, 32'h10); end
      dip1[39:32] = 8'h5A;
      ticks(20);
      rd1(32'h7f30, d);
      tests_run++;
      if (d !== 32'hA5) begin tests_failed++; $display("FAIL bank4_word1: got %h want %h", d, 32'hA5); end
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h10) begin tests_failed++; $display("FAIL bank4_status: got %h want %h", d, 32'h10); end
      tests_run++;
      if (irq1 !== 1'b1) begin tests_failed++; $display("FAIL irq_asserted: got %b want 1", irq1); end
      wr1(32'h7f34, 32'h10);
      tests_run++;
      if (irq1 !== 1'b0) begin tests_failed++; $display("FAIL irq_after_w1c: got %b want 0", irq1); end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] d;
      dip1[15:8] = 8'h00;
      ticks(17);
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL collision_pre_status: got %h want 0", d); end
      wr1(32'h7f34, 32'h02);
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h02) begin tests_failed++; $display("FAIL collision_set_wins: got %h want %h", d, 32'h02); end
      rd1(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h0000FF01) begin tests_failed++; $display("FAIL collision_word0: got %h want %h", d, 32'h0000FF01); end
      wr1(32'h7f34, 32'h02);
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL collision_later_clear: got %h want 0", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      dip1[23:16] = 8'h00;
      ticks(10);
      reset = 1'b1;
      dip1  = '1;
      tick();
      reset = 1'b0;
      tick();
      tests_run++;
      if (sw1 !== 64'h0) begin tests_failed++; $display("FAIL midreset_sw_state: got %h want 0", sw1); end
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL midreset_status: got %h want 0", d); end
      rd1(32'h7f38, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL midreset_irq_en: got %h want 0", d); end
      ticks(40);
      rd1(32'h7f34, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL midreset_no_flag: got %h want 0", d); end
      tests_run++;
      if (sw1 !== 64'h0) begin tests_failed++; $display("FAIL midreset_sw_later: got %h want 0", sw1); end
   endtask

   task automatic test_small_cfg();
      logic [31:0] d;
      dip2 = 12'hFFE;
      ticks(17);
      rd2(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL small_early: got %h want 0", d); end
      tick();
      rd2(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h1) begin tests_failed++; $display("FAIL small_on_time: got %h want %h", d, 32'h1); end
      rd2(32'h7f30, d);
      tests_run++;
      if (d !== 32'h1) begin tests_failed++; $display("FAIL small_status: got %h want %h", d, 32'h1); end
      dip2 = 12'h000;
      ticks(20);
      rd2(32'h7f2c, d);
      tests_run++;
      if (d !== 32'h0000_0FFF) begin tests_failed++; $display("FAIL small_word_pad: got %h want %h", d, 32'h0000_0FFF); end
      rd2(32'h7f30, d);
      tests_run++;
      if (d !== 32'h7) begin tests_failed++; $display("FAIL small_status_all: got %h want %h", d, 32'h7); end
      tests_run++;
      if (sw2 !== 12'hFFF) begin tests_failed++; $display("FAIL small_sw_state: got %h want %h", sw2, 12'hFFF); end
   endtask

   initial begin
      bus1.addr  = 32'h7f2c;
      bus1.we    = 1'b0;
      bus1.wdata = '0;
      bus2.addr  = 32'h7f2c;
      bus2.we    = 1'b0;
      bus2.wdata = '0;
      test_reset();
      test_latency();
      test_glitch();
      test_irq();
      test_w1c_collision();
      test_reset_mid();
      test_small_cfg();
      rv = 32'(tests_run);
      $display("[TB] %0d tests run, %0d failed", rv, tests_failed);
      $finish;
   end

endmodule
